// File: rtl/match_controller_if.sv
// Signal bundle between the match controller and the hit-detector / sprite / HUD side.
// The controller uses the slave view. The master view drives start and the hit levels.
interface match_controller_if #(
  parameter int unsigned SCORE_W = 5
);
  logic               start;
  logic               player_1_hit;
  logic               player_2_hit;
  logic               round_reset;
  logic               play_enable;
  logic [SCORE_W-1:0] player_1_score;
  logic [SCORE_W-1:0] player_2_score;
  logic               game_over;
  logic [1:0]         winner;
  logic [2:0]         state;

  modport master (
    output start, player_1_hit, player_2_hit,
    input  round_reset, play_enable, player_1_score, player_2_score,
           game_over, winner, state
  );

  modport slave (
    input  start, player_1_hit, player_2_hit,
    output round_reset, play_enable, player_1_score, player_2_score,
           game_over, winner, state
  );
endinterface

// File: rtl/match_controller.sv
// Two-player match sequencer: spawn, ready countdown, play, post-hit freeze, game over; owns both scores.
// Optional WIN_BY_TWO_EN: a win also needs a two-point lead (or any lead at score saturation).
module match_controller #(
  parameter int unsigned SCORE_W       = 5,
  parameter int unsigned WIN_SCORE     = 5,
  parameter int unsigned READY_FRAMES  = 60,
  parameter int unsigned FREEZE_FRAMES = 30,
  parameter int unsigned CNT_W         = 7
) (
  input logic               frame_clk,
  input logic               Reset_n,
  match_controller_if.slave bus
);

  localparam int unsigned SX_W = SCORE_W + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SX_W-1:0]    WIN_THR     = SX_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   READY_LOAD  = CNT_W'(READY_FRAMES - 1);
  localparam logic [CNT_W-1:0]   FREEZE_LOAD = CNT_W'(FREEZE_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPAWN      = 3'd1,
    COUNTDOWN  = 3'd2,
    PLAY       = 3'd3,
    HIT_FREEZE = 3'd4,
    GAME_OVER  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic               rr_q, rr_d, pe_q, pe_d, go_q, go_d;
  logic [1:0]         win_q, win_d;
  logic               p1_prev, p2_prev;
  logic               e1, e2;
  logic [SX_W-1:0]    s1_x, s2_x;
  logic               p1_wins, p2_wins;

  // Rising-edge detect turns the detector's hit levels into single score events
  assign e1 = bus.player_1_hit & ~p1_prev;
  assign e2 = bus.player_2_hit & ~p2_prev;

  assign s1_x = {1'b0, s1_q};
  assign s2_x = {1'b0, s2_q};

`ifdef WIN_BY_TWO_EN
  assign p1_wins = ((s1_x >= WIN_THR) && (s1_x >= s2_x + SX_W'(2))) ||
                   ((s1_q == SCORE_MAX) && (s1_q > s2_q));
  assign p2_wins = ((s2_x >= WIN_THR) && (s2_x >= s1_x + SX_W'(2))) ||
                   ((s2_q == SCORE_MAX) && (s2_q > s1_q));
`else
  assign p1_wins = (s1_x >= WIN_THR);
  assign p2_wins = (s2_x >= WIN_THR);
`endif

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SPAWN;
          s1_d    = '0;
          s2_d    = '0;
        end
      end
      SPAWN: begin
        state_d = COUNTDOWN;
        timer_d = READY_LOAD;
      end
      COUNTDOWN: begin
        if (timer_q == '0) state_d = PLAY;
        else               timer_d = timer_q - CNT_W'(1);
      end
      PLAY: begin
        if (e1 | e2) begin
          state_d = HIT_FREEZE;
          timer_d = FREEZE_LOAD;
          // A same-frame double hit is a draw: neither score moves
          if (e2 && !e1 && (s1_q != SCORE_MAX)) s1_d = s1_q + SCORE_W'(1);
          if (e1 && !e2 && (s2_q != SCORE_MAX)) s2_d = s2_q + SCORE_W'(1);
        end
      end
      HIT_FREEZE: begin
        if (timer_q == '0) begin
          if (p1_wins || p2_wins) begin
            state_d = GAME_OVER;
            win_d   = p1_wins ? 2'b01 : 2'b10;
          end else begin
            state_d = SPAWN;
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      GAME_OVER: begin
        win_d = win_q;
        if (bus.start) begin
          state_d = SPAWN;
          s1_d    = '0;
          s2_d    = '0;
          win_d   = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
    rr_d = (state_d == SPAWN);
    pe_d = (state_d == PLAY);
    go_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      timer_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      rr_q    <= 1'b0;
      pe_q    <= 1'b0;
      go_q    <= 1'b0;
      win_q   <= 2'b00;
      p1_prev <= 1'b0;
      p2_prev <= 1'b0;
    end else begin
      timer_q <= timer_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      rr_q    <= rr_d;
      pe_q    <= pe_d;
      go_q    <= go_d;
      win_q   <= win_d;
      p1_prev <= bus.player_1_hit;
      p2_prev <= bus.player_2_hit;
    end
  end

  assign bus.round_reset    = rr_q;
  assign bus.play_enable    = pe_q;
  assign bus.player_1_score = s1_q;
  assign bus.player_2_score = s2_q;
  assign bus.game_over      = go_q;
  assign bus.winner         = win_q;
  assign bus.state          = state_q;

endmodule
